// File: rtl/bootrom_arb_pkg.sv
// bootrom_arb_pkg: shared state type and sizing constants for the boot ROM
// port arbiter and its round-robin picker.
package bootrom_arb_pkg;
   typedef enum logic {IDLE, BURST} state_t;
   localparam int LEN_W = 4;
   localparam int DEF_AW = 16;
   localparam int DEF_DW = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker; search starts one past the last accepted
// index, and the pointer only moves when the grant is actually accepted.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic                     accept,
   output logic [NREQ-1:0]          grant,
   output logic [$clog2(NREQ)-1:0]  grant_idx
);
   localparam int IW = $clog2(NREQ);
   logic [IW-1:0] last;
   // Walk the offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      grant = '0;
      grant_idx = '0;
      for (int i = NREQ; i >= 1; i--) begin
         if (req[(int'(last) + i) % NREQ]) begin
            grant = '0;
            grant[(int'(last) + i) % NREQ] = 1'b1;
            grant_idx = IW'((int'(last) + i) % NREQ);
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset)
         last <= IW'(NREQ - 1);
      else if (accept)
         last <= grant_idx;
   end
endmodule

// File: rtl/bootrom_port_arbiter.sv
// bootrom_port_arbiter: shares one synchronous boot ROM between NREQ burst
// requesters; one beat per cycle with a single registered response stage.
module bootrom_port_arbiter
   import bootrom_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = DEF_AW,
   parameter int DW   = DEF_DW
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ*LEN_W-1:0]    req_len,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DW-1:0]            resp_data,
   output logic [$clog2(NREQ)-1:0]  resp_id,
   output logic                     resp_last,
   output logic                     rom_me,
   output logic                     rom_oe,
   output logic [AW-1:0]            rom_address,
   input  logic [DW-1:0]            rom_q
);
   localparam int IW = $clog2(NREQ);
   state_t state, state_n;
   logic [NREQ-1:0] grant;
   logic [IW-1:0] grant_idx, id;
   logic [AW-1:0] start;
   logic [LEN_W-1:0] len;
   logic [LEN_W:0] cnt;
   logic accept, issue, done;
   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clock     (clock),
      .reset     (reset),
      .req       (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );
   // The ROM output register is the response stage, so a stall just withholds rom_me.
   always_comb begin
      accept = state == IDLE && |req_valid;
      req_ready = state == IDLE ? grant : '0;
      issue = state == BURST && cnt <= {1'b0, len} && (!resp_valid || resp_ready);
      done = resp_valid && resp_ready && resp_last;
      state_n = accept ? BURST : done ? IDLE : state;
      rom_me = issue;
      rom_address = issue ? start + AW'(cnt) : '0;
      rom_oe = resp_valid;
      resp_data = rom_q;
   end
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         start <= '0;
         len <= '0;
         id <= '0;
         resp_valid <= 1'b0;
         resp_last <= 1'b0;
         resp_id <= '0;
      end else begin
         if (accept) begin
            start <= req_addr[grant_idx*AW +: AW];
            len <= req_len[grant_idx*LEN_W +: LEN_W];
            id <= grant_idx;
            cnt <= '0;
         end
         if (issue) begin
            cnt <= cnt + 1'b1;
            resp_valid <= 1'b1;
            resp_last <= cnt == {1'b0, len};
            resp_id <= id;
         end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_last <= 1'b0;
         end
      end
   end
endmodule
